// File: rtl/exe_adder_pipe.sv
// Pipelined WIDTH-bit add/sub with valid/ready flow control and carry chain split across STAGES slices.
// Define EXE_ADDER_SAT_EN to clamp c on overflow/borrow instead of wrapping.

module exe_adder_slice #(
    parameter int SL = 16
) (
    input  logic [SL-1:0] a,
    input  logic [SL-1:0] b,
    input  logic          cin,
    output logic [SL-1:0] s,
    output logic          cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SL{1'b0}}, cin};
endmodule

module exe_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             ovf
);
    localparam int SL = WIDTH / STAGES;

    logic              adv;
    logic [STAGES:1]   vld_pipe;

    // Whole pipe advances together; only a blocked output slot stalls it.
    assign adv       = !(vld_pipe[STAGES] && !out_ready);
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            for (int i = STAGES; i > 1; i--) vld_pipe[i] <= vld_pipe[i-1];
            vld_pipe[1] <= in_valid;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int RW = WIDTH - s*SL;  // operand bits not yet consumed
        localparam int DW = s*SL;          // result bits already produced

        logic [RW-1:0]    pa, pb;
        logic [DW:0]      ps;              // {carry into this slice, finished low bits}
        logic             psub, psgn, pas, pbs;
        logic [SL-1:0]    ss;
        logic             sc;
        logic [DW+SL:0]   nxt;
        logic [DW+SL:0]   q_sum;
        logic             q_sub, q_sgn, q_as, q_bs;

        if (s == 0) begin : g_head
            // Subtract is a + ~b + 1: the +1 rides in as the first carry-in.
            assign pa   = a;
            assign pb   = sub ? ~b : b;
            assign ps   = sub;
            assign psub = sub;
            assign psgn = sgn;
            assign pas  = a[WIDTH-1];
            assign pbs  = pb[WIDTH-1];
            assign nxt  = {sc, ss};
        end else begin : g_body
            assign pa   = g_stg[s-1].g_fwd.q_a;
            assign pb   = g_stg[s-1].g_fwd.q_b;
            assign ps   = g_stg[s-1].q_sum;
            assign psub = g_stg[s-1].q_sub;
            assign psgn = g_stg[s-1].q_sgn;
            assign pas  = g_stg[s-1].q_as;
            assign pbs  = g_stg[s-1].q_bs;
            assign nxt  = {sc, ss, ps[DW-1:0]};
        end

        exe_adder_slice #(.SL(SL)) u_slice (
            .a   (pa[SL-1:0]),
            .b   (pb[SL-1:0]),
            .cin (ps[DW]),
            .s   (ss),
            .cout(sc)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_sum <= '0;
                q_sub <= 1'b0;
                q_sgn <= 1'b0;
                q_as  <= 1'b0;
                q_bs  <= 1'b0;
            end else if (adv) begin
                q_sum <= nxt;
                q_sub <= psub;
                q_sgn <= psgn;
                q_as  <= pas;
                q_bs  <= pbs;
            end
        end

        // Upper operand slices travel on until their stage consumes them.
        if (RW > SL) begin : g_fwd
            logic [RW-SL-1:0] q_a, q_b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_a <= '0;
                    q_b <= '0;
                end else if (adv) begin
                    q_a <= pa[RW-1:SL];
                    q_b <= pb[RW-1:SL];
                end
            end
        end
    end

    logic [WIDTH-1:0] raw;
    logic             s_ovf, u_ovf, o_sub, o_sgn, o_as, o_bs;

    assign raw   = g_stg[STAGES-1].q_sum[WIDTH-1:0];
    assign carry = g_stg[STAGES-1].q_sum[WIDTH];
    assign o_sub = g_stg[STAGES-1].q_sub;
    assign o_sgn = g_stg[STAGES-1].q_sgn;
    assign o_as  = g_stg[STAGES-1].q_as;
    assign o_bs  = g_stg[STAGES-1].q_bs;

    assign s_ovf = (o_as == o_bs) && (raw[WIDTH-1] != o_as);
    assign u_ovf = o_sub ? !carry : carry;
    assign ovf   = o_sgn ? s_ovf : u_ovf;

`ifdef EXE_ADDER_SAT_EN
    // Signed clamp direction follows a's sign, which equals the effective operand's on overflow.
    always_comb begin
        c = raw;
        if (ovf) begin
            if (o_sgn) c = o_as ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else       c = o_sub ? '0 : '1;
        end
    end
`else
    assign c = raw;
`endif

endmodule
